// File: rtl/trap_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trap_sequencer: picks the oldest exception/interrupt, drains the      |
// | pipeline, pulses trap_req, writes the trap CSRs and redirects fetch.  |
// | Optional interrupt path: define HARVOS_TRAP_IRQ_EN.                   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module trap_sequencer #(
  parameter int NSRC = 4,
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NSRC-1:0]      exc_valid,
  input  logic [5*NSRC-1:0]    exc_cause,
  input  logic [XLEN*NSRC-1:0] exc_tval,
  input  logic [XLEN*NSRC-1:0] exc_pc,
  input  logic                 irq_pending,
  input  logic [4:0]           irq_cause,
  input  logic [XLEN-1:0]      irq_pc,
  input  logic [XLEN-1:0]      sstatus_q,
  input  logic                 priv_s,
  output logic                 flush_req,
  input  logic                 flush_ack,
  output logic                 trap_req,
  output logic [4:0]           trap_scause,
  output logic [XLEN-1:0]      trap_stval,
  output logic [XLEN-1:0]      cur_pc,
  input  logic [XLEN-1:0]      trap_target_pc,
  input  logic [XLEN-1:0]      sepc_to_write,
  output logic                 csr_we,
  output logic [11:0]          csr_addr,
  output logic [XLEN-1:0]      csr_wdata,
  output logic                 redirect_valid,
  output logic [XLEN-1:0]      redirect_pc,
  output logic                 trap_busy
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_FLUSH      = 3'd1;
  localparam logic [2:0] S_TRAP       = 3'd2;
  localparam logic [2:0] S_WR_SEPC    = 3'd3;
  localparam logic [2:0] S_WR_SCAUSE  = 3'd4;
  localparam logic [2:0] S_WR_STVAL   = 3'd5;
  localparam logic [2:0] S_WR_SSTATUS = 3'd6;
  localparam logic [2:0] S_REDIRECT   = 3'd7;

  logic [2:0]      state_q, state_d;
  logic [4:0]      cause_q, cause_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic [XLEN-1:0] sepc_q, sepc_d;
  logic            is_irq_q, is_irq_d;
  logic [XLEN-1:0] sstatus_new;

`ifdef HARVOS_TRAP_IRQ_EN
  logic irq_take;
  assign irq_take = irq_pending && (!priv_s || sstatus_q[1]);
`else
  logic unused_irq;
  assign unused_irq = ^{irq_pending, irq_cause, irq_pc};
`endif

  always_comb begin
    sstatus_new    = sstatus_q;
    sstatus_new[5] = sstatus_q[1];
    sstatus_new[1] = 1'b0;
    sstatus_new[8] = priv_s;
  end

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    tval_d   = tval_q;
    pc_d     = pc_q;
    tgt_d    = tgt_q;
    sepc_d   = sepc_q;
    is_irq_d = is_irq_q;
    case (state_q)
      S_IDLE: begin
        if (|exc_valid) begin
          // Ascending scan: the last (highest-index, oldest) set source wins.
          for (int i = 0; i < NSRC; i++) begin
            if (exc_valid[i]) begin
              cause_d = exc_cause[5*i +: 5];
              tval_d  = exc_tval[XLEN*i +: XLEN];
              pc_d    = exc_pc[XLEN*i +: XLEN];
            end
          end
          is_irq_d = 1'b0;
          state_d  = S_FLUSH;
        end
`ifdef HARVOS_TRAP_IRQ_EN
        else if (irq_take) begin
          cause_d  = irq_cause;
          tval_d   = '0;
          pc_d     = irq_pc;
          is_irq_d = 1'b1;
          state_d  = S_FLUSH;
        end
`endif
      end
      S_FLUSH:      if (flush_ack) state_d = S_TRAP;
      S_TRAP: begin
        tgt_d   = trap_target_pc;
        sepc_d  = sepc_to_write;
        state_d = S_WR_SEPC;
      end
      S_WR_SEPC:    state_d = S_WR_SCAUSE;
      S_WR_SCAUSE:  state_d = S_WR_STVAL;
      S_WR_STVAL:   state_d = S_WR_SSTATUS;
      S_WR_SSTATUS: state_d = S_REDIRECT;
      default:      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cause_q  <= '0;
      tval_q   <= '0;
      pc_q     <= '0;
      tgt_q    <= '0;
      sepc_q   <= '0;
      is_irq_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      tval_q   <= tval_d;
      pc_q     <= pc_d;
      tgt_q    <= tgt_d;
      sepc_q   <= sepc_d;
      is_irq_q <= is_irq_d;
    end
  end

  // All outputs decode from the state flop, so they are zero in IDLE and after reset.
  always_comb begin
    flush_req      = (state_q == S_FLUSH);
    trap_req       = (state_q == S_TRAP);
    trap_scause    = '0;
    trap_stval     = '0;
    cur_pc         = '0;
    csr_we         = 1'b0;
    csr_addr       = '0;
    csr_wdata      = '0;
    redirect_valid = (state_q == S_REDIRECT);
    redirect_pc    = '0;
    trap_busy      = (state_q != S_IDLE);
    case (state_q)
      S_TRAP: begin
        trap_scause = cause_q;
        trap_stval  = tval_q;
        cur_pc      = pc_q;
      end
      S_WR_SEPC: begin
        csr_we    = 1'b1;
        csr_addr  = 12'h141;
        csr_wdata = sepc_q;
      end
      S_WR_SCAUSE: begin
        csr_we    = 1'b1;
        csr_addr  = 12'h142;
        csr_wdata = {is_irq_q, {(XLEN-6){1'b0}}, cause_q};
      end
      S_WR_STVAL: begin
        csr_we    = 1'b1;
        csr_addr  = 12'h143;
        csr_wdata = tval_q;
      end
      S_WR_SSTATUS: begin
        csr_we    = 1'b1;
        csr_addr  = 12'h100;
        csr_wdata = sstatus_new;
      end
      S_REDIRECT:   redirect_pc = tgt_q;
      default:      ;
    endcase
  end

endmodule
`default_nettype wire
